// File: rtl/seq_pkg.sv
// Shared types and helpers for the instruction sequencer and decode controller.
// Holds the FSM state encoding, ARM condition codes, opcode classes and cond_pass().
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // nzcv packs N in bit 3 down to V in bit 0; the 1111 encoding executes unconditionally.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Loadable down-counter with a zero flag; used for the imem timeout and multiply cycles.
// Decrement saturates at zero so a stalled phase cannot wrap around.
module seq_wait_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control and commit strobes.
// Defining SEQ_PERF_EN adds the cycle_cnt / instr_cnt performance counters.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int MUL_CYCLES   = 3,
  parameter int IMEM_TIMEOUT = 255
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] IR_in,
  input  logic [3:0]  Flags_in,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        dmem_req,
  output logic        commit_rd,
  output logic        commit_mem,
  output logic        commit_flags,
  output logic        busy,
  output logic        fault,
  output logic [2:0]  state_o
`ifdef SEQ_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam int             TW         = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_RELOAD = TW'(IMEM_TIMEOUT - 1);
  localparam logic [3:0]     MUL_RELOAD = 4'(MUL_CYCLES - 1);

  state_t state;
  assign state_o = state;

  // Instruction classification, read from the held IR contents.
  logic [1:0] op;
  logic       is_dp, is_br, is_mul, is_load, wb_rd, wb_flags;
  logic       unused_ir;

  assign op       = IR_in[27:26];
  assign is_dp    = (op == OP_DP);
  assign is_br    = (op == OP_BR);
  assign is_mul   = (IR_in[27:21] == 7'd0) && (IR_in[7:4] == 4'b1001);
  assign is_load  = (op == OP_MEM) && IR_in[20];
  assign wb_rd    = (is_dp && (IR_in[24:23] != 2'b10)) || is_load || (is_br && IR_in[24]);
  assign wb_flags = is_dp && IR_in[20];
  assign unused_ir = ^{IR_in[19:8], IR_in[3:0]};

  logic tmo_load, tmo_zero, mul_zero;

  assign tmo_load = run && ((state == S_IDLE) || (state == S_WB));

  seq_wait_counter #(.WIDTH(TW)) u_imem_tmo (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .load     (tmo_load),
    .dec      (state == S_FETCH),
    .load_val (TMO_RELOAD),
    .zero     (tmo_zero)
  );

  seq_wait_counter #(.WIDTH(4)) u_mul_wait (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .load     (state == S_DECODE),
    .dec      (state == S_EXEC),
    .load_val (MUL_RELOAD),
    .zero     (mul_zero)
  );

  // Handshake: a request is raised on entry to its phase and held every cycle until the
  // matching ready is sampled high; that ready cycle is the transfer, and the only cycle
  // in which the Mealy ir_load / commit_mem strobes can fire.
  assign ir_load    = (state == S_FETCH) && imem_ready;
  assign commit_mem = (state == S_MEM) && dmem_ready && !IR_in[20];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      imem_req     <= 1'b0;
      dmem_req     <= 1'b0;
      pc_inc       <= 1'b0;
      pc_load      <= 1'b0;
      commit_rd    <= 1'b0;
      commit_flags <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      imem_req     <= 1'b0;
      dmem_req     <= 1'b0;
      pc_inc       <= 1'b0;
      pc_load      <= 1'b0;
      commit_rd    <= 1'b0;
      commit_flags <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            state <= S_DECODE;
          end else if (tmo_zero) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          // Flags are only looked at here; a failed condition retires as a plain PC step.
          if (cond_pass(IR_in[31:28], Flags_in)) begin
            state <= S_EXEC;
          end else begin
            state  <= S_WB;
            pc_inc <= 1'b1;
          end
        end
        S_EXEC: begin
          if (op == OP_MEM) begin
            state    <= S_MEM;
            dmem_req <= 1'b1;
          end else if (is_mul && !mul_zero) begin
            state <= S_EXEC;
          end else begin
            // op=11 decodes to no commits and no branch, so it retires as a skip.
            state        <= S_WB;
            commit_rd    <= wb_rd;
            commit_flags <= wb_flags;
            pc_load      <= is_br;
            pc_inc       <= !is_br;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state     <= S_WB;
            commit_rd <= is_load;
            pc_inc    <= 1'b1;
          end else begin
            dmem_req <= 1'b1;
          end
        end
        S_WB: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_FAULT: begin
          fault <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_EN
  logic pass_q;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
      pass_q    <= 1'b0;
    end else begin
      if (busy) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (state == S_DECODE) begin
        pass_q <= cond_pass(IR_in[31:28], Flags_in);
      end
      if ((state == S_WB) && pass_q) begin
        instr_cnt <= instr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed instructions, random instructions, imem timeout.
// Expected per-cycle output traces come from an instruction-level model of the phase rules.
module tb_instr_sequencer;

  localparam int MULC = 3;
  localparam int TMO  = 255;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n, run, imem_ready, dmem_ready;
  logic [31:0] IR_in;
  logic [3:0]  Flags_in;
  logic        imem_req, ir_load, pc_inc, pc_load, dmem_req;
  logic        commit_rd, commit_mem, commit_flags, busy, fault;
  logic [2:0]  state_o;
`ifdef SEQ_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  logic [12:0] obs;
  logic [12:0] exp_q[$];
  logic [6:0]  stim_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  instr_sequencer #(.MUL_CYCLES(MULC), .IMEM_TIMEOUT(TMO)) dut (
    .CLOCK_50     (CLOCK_50),
    .rst_n        (rst_n),
    .run          (run),
    .IR_in        (IR_in),
    .Flags_in     (Flags_in),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .dmem_req     (dmem_req),
    .commit_rd    (commit_rd),
    .commit_mem   (commit_mem),
    .commit_flags (commit_flags),
    .busy         (busy),
    .fault        (fault),
    .state_o      (state_o)
`ifdef SEQ_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instr_cnt    (instr_cnt)
`endif
  );

  assign obs = {state_o, imem_req, ir_load, pc_inc, pc_load, dmem_req,
                commit_rd, commit_mem, commit_flags, busy, fault};

  // Expected output vector, same field order as obs.
  function automatic logic [12:0] vec(input logic [2:0] st, input logic req, ild, inc, ld,
                                      dreq, rd, mem, fl, bsy, flt);
    return {st, req, ild, inc, ld, dreq, rd, mem, fl, bsy, flt};
  endfunction

  // Condition check written as "base test, inverted by the low cond bit".
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
  endfunction

  task automatic check(input logic [12:0] e, input string tag);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, cyc_no, obs, e);
    end
  endtask

  task automatic push(input logic irdy, drdy, rn, input logic [3:0] fl, input logic [12:0] e);
    exp_q.push_back(e);
    stim_q.push_back({irdy, drdy, rn, fl});
  endtask

  // Drive one queued stimulus per cycle at the falling edge, then compare outputs.
  task automatic drain(input logic [31:0] ir, input string tag);
    logic [6:0]  s;
    logic [12:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      @(negedge CLOCK_50);
      IR_in = ir;
      {imem_ready, dmem_ready, run, Flags_in} = s;
      cyc_no++;
      #1;
      check(e, tag);
    end
  endtask

  // Model one instruction from its FETCH cycle: iw imem waits, dw dmem waits.
  task automatic do_instr(input logic [31:0] ir, input logic [3:0] fl, input int iw,
                          input int dw, input logic run_after, input string tag);
    logic [1:0] op;
    logic       mul, pass, rd, fg, br, is_mem, st;
    int         ex_n;
    op     = ir[27:26];
    mul    = (ir[27:21] == 7'd0) && (ir[7:4] == 4'd9);
    pass   = cond_ref(ir[31:28], fl);
    is_mem = (op == 2'd1);
    st     = is_mem && !ir[20];
    br     = (op == 2'd2);
    case (op)
      2'd0:    rd = !((ir[24:21] >= 4'd8) && (ir[24:21] <= 4'd11));
      2'd1:    rd = ir[20];
      2'd2:    rd = ir[24];
      default: rd = 1'b0;
    endcase
    fg   = (op == 2'd0) && ir[20];
    ex_n = ((op == 2'd0) && mul) ? MULC : 1;
    for (int i = 0; i < iw; i++) push(1'b0, 1'b0, 1'b1, fl, vec(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    push(1'b1, 1'b0, 1'b1, fl, vec(3'd1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    push(1'b0, 1'b0, 1'b1, fl, vec(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    if (pass) begin
      for (int i = 0; i < ex_n; i++)
        push(1'b0, 1'b0, 1'b1, 4'($urandom), vec(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      if (is_mem) begin
        for (int i = 0; i < dw; i++)
          push(1'b0, 1'b0, 1'b1, 4'($urandom), vec(3'd4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        push(1'b0, 1'b1, 1'b1, 4'($urandom), vec(3'd4, 0, 0, 0, 0, 1, 0, st, 0, 1, 0));
      end
    end
    push(1'b0, 1'b0, run_after, 4'($urandom),
         vec(3'd5, 0, 0, !(pass && br), pass && br, 0, pass && rd, 0, pass && fg, 1, 0));
    if (!run_after) push(1'b0, 1'b0, 1'b1, 4'($urandom), vec(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drain(ir, tag);
  endtask

  initial begin
    logic [31:0] rir;
    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    IR_in = 32'd0; Flags_in = 4'd0;
    #1 check(13'd0, "reset");
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;

    push(1'b0, 1'b0, 1'b0, 4'd0, 13'd0);
    push(1'b0, 1'b0, 1'b0, 4'd0, 13'd0);
    push(1'b0, 1'b0, 1'b1, 4'd0, 13'd0);
    drain(32'd0, "idle");

    do_instr(32'hE0811002, 4'b0000, 0, 0, 1'b1, "add");
    do_instr(32'hE1510002, 4'b0100, 0, 0, 1'b1, "cmp");
    do_instr(32'h0A000004, 4'b0000, 0, 0, 1'b1, "beq_skip");
    do_instr(32'hE5812000, 4'b0000, 0, 2, 1'b1, "str");
    do_instr(32'hE0010291, 4'b0000, 0, 0, 1'b1, "mul");
    do_instr(32'hEB000010, 4'b0000, 0, 0, 1'b1, "bl");
    do_instr(32'hE5912000, 4'b0000, 2, 1, 1'b0, "ldr_idle");
    do_instr(32'h0A000004, 4'b0100, 1, 0, 1'b1, "beq_taken");

    for (int k = 0; k < 40; k++) begin
      rir = $urandom();
      if ($urandom_range(0, 5) == 0) begin
        rir[27:21] = 7'd0;
        rir[7:4]   = 4'b1001;
      end
      do_instr(rir, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
               ($urandom_range(0, 3) != 0), "random");
    end

    for (int i = 0; i < TMO; i++) push(1'b0, 1'b0, 1'b1, 4'd0, vec(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    repeat (3) push(1'b1, 1'b1, 1'b1, 4'd0, vec(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    drain(32'hE0811002, "timeout");

    #2 rst_n = 1'b0;
    #1 check(13'd0, "async_rst");
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    #1 check(13'd0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle instruction sequencer for the processor datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback phases, and evaluates the ARM condition field against NZCV.
- Emits one-cycle commit strobes that gate the decoder's write enables (register file, Dmem, flags), plus PC and IR control.
- Sits between instruction memory, the decode controller and the datapath. It is the sole owner of when state changes.

Parameters:
- MUL_CYCLES, 3: EXEC cycles spent on a multiply (IR[27:21]=0000000, IR[7:4]=1001); legal range 1..15.
- IMEM_TIMEOUT, 255: cycles imem_req may stay unanswered before fault is raised.

Ports:
- CLOCK_50  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; high allows a new fetch to start
- IR_in  input  32  instruction register contents
- Flags_in  input  4  NZCV, bit3=N, bit0=V
- imem_ready  input  1  instruction memory has data valid this cycle
- dmem_ready  input  1  data memory completes access this cycle
- imem_req  output  1  instruction fetch request
- ir_load  output  1  capture instruction into IR
- pc_inc  output  1  PC <= PC+4
- pc_load  output  1  PC <= branch target
- dmem_req  output  1  data memory access request
- commit_rd  output  1  enable register-file write
- commit_mem  output  1  enable Dmem write
- commit_flags  output  1  enable flags write
- busy  output  1  high in any state except IDLE
- fault  output  1  sticky imem timeout
- state_o  output  3  current state encoding, for debug

Behaviour:
- Reset (async, rst_n low): state=IDLE. All outputs are 0. Timeout and multiply counters clear. fault clears. Reset asserted mid-instruction abandons it with no commit.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. All outputs are registered Moore outputs, except ir_load and commit_mem, which are Mealy on ready inputs.
- IDLE: when run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 until imem_ready.
  - On imem_ready: ir_load=1 in the same cycle, then go to DECODE.
  - If imem_ready has not arrived after IMEM_TIMEOUT request cycles: go to FAULT and set fault=1.
- DECODE: evaluate cond = IR_in[31:28] against Flags_in (EQ..LE; AL and 1111 always pass).
  - Fail: go to WB with all commit_* suppressed (skip; pc_inc only).
  - Pass: go to EXEC.
- EXEC:
  - Multiply: stays MUL_CYCLES cycles, counter counting down, then WB.
  - op=01 (memory): go to MEM.
  - op=00 and op=10: go to WB.
  - op=11 is undefined: go to WB as a skip.
- MEM:
  - dmem_req=1 until dmem_ready.
  - Store (L=0): commit_mem=1 in the dmem_ready cycle, then WB with commit_rd=0.
  - Load (L=1): go to WB.
- WB: a single cycle that decides all commits and PC updates.
  - commit_rd=1 for:
    - data-processing ops other than TST/TEQ/CMP/CMN (IR[24:21] 1000..1011);
    - loads;
    - branches with L=1 (IR[24]).
  - commit_flags = IR[20] for data-processing ops only.
  - Branch: pc_load=1, pc_inc=0. All other paths: pc_inc=1.
  - Next state: FETCH if run=1, else IDLE.
- pc_inc and pc_load are never both high. Every commit_* strobe is exactly one cycle wide.
- Flags are sampled only in DECODE, so later flag changes do not alter the decision.
- FAULT: absorbing state; only reset leaves it.
- Minimum latency: 4 cycles for ALU/branch ops (zero-wait imem); 5 cycles plus dmem waits for loads.

Optional Feature:
- SEQ_PERF_EN defined:
  - Adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle busy=1.
  - instr_cnt increments on each WB cycle where the condition passed.
  - Both wrap at 2^32.
- Undefined: neither port nor counter exists.

Decomposition:
- Package seq_pkg holds:
  - state_t enum;
  - cond code constants (COND_EQ..COND_AL);
  - opcode constants OP_DP=00, OP_MEM=01, OP_BR=10;
  - function cond_pass(cond, nzcv), shared with the decode controller.
- One sub-module: seq_wait_counter, a loadable down-counter with zero flag. Instantiated twice: imem timeout and multiply cycles.

Test Plan:
- ADD R1 (E0811002), zero-wait imem and run=1 -> states 1,2,3,5. commit_rd=1 in the WB cycle, commit_flags=0, pc_inc=1. Back in FETCH 4 cycles after the first req.
- CMP with S (E1510002), Flags_in=0100 -> commit_rd=0, commit_flags=1.
- Then BEQ with Z=0 (0A000004) -> DECODE goes directly to WB. No commits, pc_inc=1, pc_load=0.
- STR (E5812000) with dmem_ready delayed 3 cycles -> dmem_req high 3 cycles. commit_mem=1 only in the ready cycle, then WB with commit_rd=0.
- MUL (E0010291) with MUL_CYCLES=3 -> exactly 3 EXEC cycles, then commit_rd=1.
- BL (EB000010) -> pc_load=1, commit_rd=1.
- imem_ready held low for 255 cycles -> FAULT with fault=1. rst_n low mid-FAULT clears everything asynchronously.
